// File: rtl/bip_mem_pkg.sv
// ============================================================================
// bip_mem_pkg: address map, state encoding and reset constants for the BIP
// data memory.  Revision: 1.0
// ============================================================================
`default_nettype none

package bip_mem_pkg;

    localparam logic [10:0] ADDR_PORT_OUT  = 11'h7F8;
    localparam logic [10:0] ADDR_PORT_IN   = 11'h7F9;
    localparam logic [10:0] ADDR_TIMER     = 11'h7FA;
    localparam logic [10:0] ADDR_TIMER_CMP = 11'h7FB;
    localparam logic [10:0] ADDR_STATUS    = 11'h7FC;

    localparam logic [15:0] TIMER_CMP_RST  = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/bip_mem_timer.sv
// ============================================================================
// bip_mem_timer: free-running compare timer with a sticky match flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bip_mem_timer
    import bip_mem_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         cmp_we_i,
    input  logic         clear_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] cmp_o,
    output logic         match_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] cmp_q;
    logic         match_q;

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            cmp_q   <= W'(TIMER_CMP_RST);
            match_q <= 1'b0;
        end else if (en_i) begin
            count_q <= load_i ? data_i : count_q + W'(1);
            if (cmp_we_i) begin
                cmp_q <= data_i;
            end
            // Match uses the pre-update count and beats a same-edge clear.
            if (count_q == cmp_q) begin
                match_q <= 1'b1;
            end else if (clear_i) begin
                match_q <= 1'b0;
            end
        end
    end

    assign count_o = count_q;
    assign cmp_o   = cmp_q;
    assign match_o = match_q;

endmodule

`default_nettype wire

// File: rtl/bip_data_memory.sv
// ============================================================================
// bip_data_memory: BIP I data RAM with zero-fill sweep and memory-mapped
// output port, synchronised input port and compare timer.  Revision: 1.0
// ============================================================================
`default_nettype none

module bip_data_memory
    import bip_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter int RAM_DEPTH  = 1024
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Rd,
    input  logic                  Wr,
    input  logic [ADDR_WIDTH-1:0] DataAddr,
    input  logic [DATA_WIDTH-1:0] In_Data,
    output logic [DATA_WIDTH-1:0] Out_Data,
    input  logic [DATA_WIDTH-1:0] Port_In,
    output logic [DATA_WIDTH-1:0] Port_Out,
    output logic                  Timer_Irq,
    output logic                  Busy
);

    localparam int                RAM_AW    = $clog2(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] RAM_LIMIT = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [RAM_AW-1:0] LAST_PTR  = RAM_AW'(RAM_DEPTH - 1);

    state_e                state_q;
    logic [RAM_AW-1:0]     clr_ptr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] port_out_q;
    logic [DATA_WIDTH-1:0] sync1_q;
    logic [DATA_WIDTH-1:0] sync2_q;
    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    logic                  w_ready;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_in_ram;
    logic [RAM_AW-1:0]     w_ram_idx;
    logic                  w_ram_we;
    logic [RAM_AW-1:0]     w_ram_waddr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [DATA_WIDTH-1:0] w_tmr_count;
    logic [DATA_WIDTH-1:0] w_tmr_cmp;
    logic                  w_tmr_match;

    assign w_ready   = (state_q == ST_READY);
    assign w_rd      = w_ready && Rd;
    assign w_wr      = w_ready && Wr && !Rd;
    assign w_in_ram  = ({1'b0, DataAddr} < RAM_LIMIT);
    assign w_ram_idx = DataAddr[RAM_AW-1:0];

    bip_mem_timer #(
        .W (DATA_WIDTH)
    ) u_timer (
        .clk_i    (Clock),
        .rst_ni   (Reset),
        .en_i     (w_ready),
        .load_i   (w_wr && DataAddr == ADDR_WIDTH'(ADDR_TIMER)),
        .data_i   (In_Data),
        .cmp_we_i (w_wr && DataAddr == ADDR_WIDTH'(ADDR_TIMER_CMP)),
        .clear_i  (w_wr && DataAddr == ADDR_WIDTH'(ADDR_STATUS) && In_Data[0]),
        .count_o  (w_tmr_count),
        .cmp_o    (w_tmr_cmp),
        .match_o  (w_tmr_match)
    );

    // Single RAM write port shared by the zero-fill sweep and the CPU.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = clr_ptr_q;
        w_ram_wdata = '0;
        if (!w_ready) begin
            w_ram_we = 1'b1;
        end else if (w_wr && w_in_ram) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = w_ram_idx;
            w_ram_wdata = In_Data;
        end
    end

    always_ff @(negedge Clock) begin
        if (w_ram_we) begin
            mem_q[w_ram_waddr] <= w_ram_wdata;
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (w_in_ram) begin
            w_rd_data = mem_q[w_ram_idx];
        end else begin
            case (DataAddr)
                ADDR_WIDTH'(ADDR_PORT_OUT):  w_rd_data = port_out_q;
                ADDR_WIDTH'(ADDR_PORT_IN):   w_rd_data = sync2_q;
                ADDR_WIDTH'(ADDR_TIMER):     w_rd_data = w_tmr_count;
                ADDR_WIDTH'(ADDR_TIMER_CMP): w_rd_data = w_tmr_cmp;
                ADDR_WIDTH'(ADDR_STATUS):    w_rd_data = {{(DATA_WIDTH-1){1'b0}}, w_tmr_match};
                default:                     w_rd_data = '0;
            endcase
        end
    end

    always_ff @(negedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            out_data_q <= '0;
            port_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            sync1_q <= Port_In;
            sync2_q <= sync1_q;
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + RAM_AW'(1);
                    if (clr_ptr_q == LAST_PTR) begin
                        state_q <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (w_rd) begin
                        out_data_q <= w_rd_data;
                    end
                    if (w_wr && DataAddr == ADDR_WIDTH'(ADDR_PORT_OUT)) begin
                        port_out_q <= In_Data;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    assign Out_Data  = out_data_q;
    assign Port_Out  = port_out_q;
    assign Timer_Irq = w_tmr_match;
    assign Busy      = (state_q == ST_CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_bip_data_memory.sv
// ============================================================================
// tb_bip_data_memory: directed self-checking bench for bip_data_memory
// (RAM_DEPTH = 8).  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bip_data_memory;

    localparam int DEPTH = 8;

    localparam logic [10:0] A_PORT_OUT  = 11'h7F8;
    localparam logic [10:0] A_PORT_IN   = 11'h7F9;
    localparam logic [10:0] A_TIMER     = 11'h7FA;
    localparam logic [10:0] A_TIMER_CMP = 11'h7FB;
    localparam logic [10:0] A_STATUS    = 11'h7FC;

    logic        Clock;
    logic        Reset;
    logic        Rd;
    logic        Wr;
    logic [10:0] DataAddr;
    logic [15:0] In_Data;
    logic [15:0] Out_Data;
    logic [15:0] Port_In;
    logic [15:0] Port_Out;
    logic        Timer_Irq;
    logic        Busy;

    int checks;
    int errors;

    bip_data_memory #(
        .ADDR_WIDTH (11),
        .DATA_WIDTH (16),
        .RAM_DEPTH  (DEPTH)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Rd        (Rd),
        .Wr        (Wr),
        .DataAddr  (DataAddr),
        .In_Data   (In_Data),
        .Out_Data  (Out_Data),
        .Port_In   (Port_In),
        .Port_Out  (Port_Out),
        .Timer_Irq (Timer_Irq),
        .Busy      (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clock);
        #1;
    endtask

    task automatic do_write(input logic [10:0] a, input logic [15:0] d);
        DataAddr = a; In_Data = d; Wr = 1'b1; Rd = 1'b0;
        step();
        Wr = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [10:0] a, input logic [15:0] exp);
        DataAddr = a; Rd = 1'b1; Wr = 1'b0;
        step();
        Rd = 1'b0;
        check(tag, Out_Data, exp);
    endtask

    task automatic busy_len(input string tag);
        int n;
        n = 0;
        while (Busy && n < 100) begin
            step();
            n++;
        end
        check(tag, 16'(n), 16'(DEPTH));
    endtask

    initial begin
        checks = 0; errors = 0;
        Reset = 1'b0; Rd = 1'b0; Wr = 1'b0;
        DataAddr = '0; In_Data = '0; Port_In = '0;

        #12;
        check("rst_out_data", Out_Data, 16'h0000);
        check("rst_port_out", Port_Out, 16'h0000);
        check("rst_irq",      16'(Timer_Irq), 16'h0000);
        check("rst_busy",     16'(Busy), 16'h0001);
        Reset = 1'b1;
        busy_len("busy_len_initial");

        // timer held still during the sweep
        do_read("timer_after_clear", A_TIMER, 16'h0000);
        do_read("ram5_cleared", 11'd5, 16'h0000);

        do_write(11'd0, 16'h0001);
        do_write(11'd1, 16'h0002);
        do_read("rd_addr0", 11'd0, 16'h0001);
        do_read("rd_addr1", 11'd1, 16'h0002);
        do_write(11'd2, 16'h0003);
        do_read("rd_addr2", 11'd2, 16'h0003);
        step();
        check("out_data_hold", Out_Data, 16'h0003);

        do_write(11'd3, 16'h7777);
        DataAddr = 11'd3; In_Data = 16'hBEEF; Rd = 1'b1; Wr = 1'b1;
        step();
        Rd = 1'b0; Wr = 1'b0;
        check("rdwr_out_old", Out_Data, 16'h7777);
        do_read("rdwr_no_write", 11'd3, 16'h7777);

        do_write(11'd7, 16'h00AA);
        do_read("ram_last_word", 11'd7, 16'h00AA);
        do_write(11'd8, 16'h1111);
        do_read("unmapped_8", 11'd8, 16'h0000);
        do_read("unmapped_7fd", 11'h7FD, 16'h0000);

        do_write(A_PORT_OUT, 16'h1234);
        check("port_out_drive", Port_Out, 16'h1234);
        do_read("port_out_read", A_PORT_OUT, 16'h1234);
        Port_In = 16'hA5A5;
        step();
        step();
        do_read("port_in_sync", A_PORT_IN, 16'hA5A5);

        do_write(A_TIMER, 16'h0010);
        do_write(A_TIMER_CMP, 16'h0014);
        step();
        step();
        step();
        check("irq_before_match", 16'(Timer_Irq), 16'h0000);
        step();
        check("irq_on_match", 16'(Timer_Irq), 16'h0001);
        do_read("status_set", A_STATUS, 16'h0001);
        do_write(A_STATUS, 16'h0001);
        check("irq_cleared", 16'(Timer_Irq), 16'h0000);
        do_read("status_clear", A_STATUS, 16'h0000);

        // match and clear on the same edge: the match wins
        do_write(A_TIMER_CMP, 16'h0030);
        do_write(A_TIMER, 16'h0030);
        do_write(A_STATUS, 16'h0001);
        check("set_beats_clear", 16'(Timer_Irq), 16'h0001);
        do_write(A_STATUS, 16'h0001);
        check("irq_cleared2", 16'(Timer_Irq), 16'h0000);

        do_write(A_TIMER_CMP, 16'h0100);
        do_write(A_TIMER, 16'hFFFE);
        do_read("wrap_fffe", A_TIMER, 16'hFFFE);
        do_read("wrap_ffff", A_TIMER, 16'hFFFF);
        do_read("wrap_0000", A_TIMER, 16'h0000);
        check("wrap_no_irq", 16'(Timer_Irq), 16'h0000);
        do_read("cmp_read", A_TIMER_CMP, 16'h0100);

        do_write(A_TIMER_CMP, 16'h0005);
        do_write(A_TIMER, 16'h0005);
        step();
        check("irq_set_again", 16'(Timer_Irq), 16'h0001);
        do_read("out_before_rst", A_PORT_OUT, 16'h1234);

        DataAddr = 11'd0; In_Data = 16'h9999; Wr = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        Wr = 1'b0;
        check("midwr_out_data", Out_Data, 16'h0000);
        check("midwr_port_out", Port_Out, 16'h0000);
        check("midwr_irq",      16'(Timer_Irq), 16'h0000);
        check("midwr_busy",     16'(Busy), 16'h0001);
        Reset = 1'b1;
        step();
        step();
        step();
        #2;
        Reset = 1'b0;
        #1;
        check("midsweep_busy", 16'(Busy), 16'h0001);
        check("midsweep_out",  Out_Data, 16'h0000);
        Reset = 1'b1;
        busy_len("busy_len_restart");
        do_read("ram0_recleared", 11'd0, 16'h0000);
        do_read("ram7_recleared", 11'd7, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
